// File: rtl/gol_row_engine.sv
// rtl/gol_row_engine.sv - row-parallel Game of Life engine with in-place 3-row sliding window
//
// Purpose: holds a HEIGHT x WIDTH board as HEIGHT row registers and advances it by
// one generation on request, computing one full row per clock. The birth/survive
// rule is sampled at start; edges either wrap (torus) or read as dead.
//
// Parameters: LOG_W (width = 2**LOG_W), LOG_H (height = 2**LOG_H), WRAP (1 = torus).
// Optional feature macro: GOL_ROW_ENGINE_STABLE_DETECT_EN (stable-generation flag).
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start                      one-cycle request to compute a generation (IDLE only)
//   rule_birth, rule_survive   bit n: birth / survival with n live neighbours
//   wr_en, wr_row, wr_data     row write port (IDLE only, wins over start)
//   rd_row, rd_data            registered row read port (always active)
//   busy, done                 busy through PRIME/SWEEP; done pulses in FINISH
//   pop_count, gen_count       live cells of last generation; generations completed
//   stable                     last generation equal to its predecessor (0 if feature off)

module gol_row_engine #(
  parameter int LOG_W = 6,
  parameter int LOG_H = 5,
  parameter int WRAP  = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [8:0]               rule_birth,
  input  logic [8:0]               rule_survive,
  input  logic                     wr_en,
  input  logic [LOG_H-1:0]         wr_row,
  input  logic [(2**LOG_W)-1:0]    wr_data,
  input  logic [LOG_H-1:0]         rd_row,
  output logic [(2**LOG_W)-1:0]    rd_data,
  output logic                     busy,
  output logic                     done,
  output logic [LOG_W+LOG_H:0]     pop_count,
  output logic [15:0]              gen_count,
  output logic                     stable
);

  localparam int WIDTH  = 2**LOG_W;
  localparam int HEIGHT = 2**LOG_H;
  localparam int PW     = LOG_W + LOG_H + 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_PRIME  = 2'd1;
  localparam logic [1:0] S_SWEEP  = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;

  logic [1:0]       state;
  logic [WIDTH-1:0] board [HEIGHT];
  logic [WIDTH-1:0] prev_row, cur_row, first_row;
  logic [LOG_H-1:0] y;
  logic [8:0]       rule_b, rule_s;
  logic [PW-1:0]    acc;

  logic             wrap_en;
  logic [LOG_H-1:0] y_next;
  logic             last_row;
  logic [WIDTH-1:0] below;
  logic [WIDTH-1:0] prev_w, prev_e, cur_w, cur_e, below_w, below_e;
  logic [WIDTH-1:0] new_row;
  logic [LOG_W:0]   row_pop;

  assign wrap_en  = (WRAP != 0);
  assign y_next   = y + LOG_H'(1);
  assign last_row = (y == LOG_H'(HEIGHT - 1));

  // Row y+1 has not been rewritten yet; the bottom neighbour of the last row is the
  // original row 0, which was overwritten at the start of the sweep, hence first_row.
  assign below = last_row ? (wrap_en ? first_row : '0) : board[y_next];

  // *_w bit x holds column x-1, *_e bit x holds column x+1; the edge bit wraps or is dead.
  assign prev_w  = {prev_row[WIDTH-2:0], wrap_en & prev_row[WIDTH-1]};
  assign prev_e  = {wrap_en & prev_row[0], prev_row[WIDTH-1:1]};
  assign cur_w   = {cur_row[WIDTH-2:0], wrap_en & cur_row[WIDTH-1]};
  assign cur_e   = {wrap_en & cur_row[0], cur_row[WIDTH-1:1]};
  assign below_w = {below[WIDTH-2:0], wrap_en & below[WIDTH-1]};
  assign below_e = {wrap_en & below[0], below[WIDTH-1:1]};

  always_comb begin
    new_row = '0;
    row_pop = '0;
    for (int x = 0; x < WIDTH; x++) begin : g_cell
      logic [3:0] nb;
      nb = 4'(prev_w[x]) + 4'(prev_row[x]) + 4'(prev_e[x])
         + 4'(cur_w[x])                    + 4'(cur_e[x])
         + 4'(below_w[x]) + 4'(below[x])   + 4'(below_e[x]);
      new_row[x] = cur_row[x] ? rule_s[nb] : rule_b[nb];
      row_pop    = row_pop + (LOG_W+1)'(new_row[x]);
    end
  end

  assign busy = (state == S_PRIME) || (state == S_SWEEP);
  assign done = (state == S_FINISH);

  // Board storage and read port. rd_data may show a torn board mid-sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < HEIGHT; i++) board[i] <= '0;
      rd_data <= '0;
    end else begin
      rd_data <= board[rd_row];
      if (state == S_IDLE && wr_en)
        board[wr_row] <= wr_data;
      else if (state == S_SWEEP)
        board[y] <= new_row;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      prev_row  <= '0;
      cur_row   <= '0;
      first_row <= '0;
      y         <= '0;
      rule_b    <= '0;
      rule_s    <= '0;
      acc       <= '0;
      pop_count <= '0;
      gen_count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!wr_en && start) begin
            rule_b <= rule_birth;
            rule_s <= rule_survive;
            state  <= S_PRIME;
          end
        end
        S_PRIME: begin
          prev_row  <= wrap_en ? board[HEIGHT-1] : '0;
          cur_row   <= board[0];
          first_row <= board[0];
          y         <= '0;
          acc       <= '0;
          state     <= S_SWEEP;
        end
        S_SWEEP: begin
          prev_row <= cur_row;
          cur_row  <= below;
          acc      <= acc + PW'(row_pop);
          y        <= y_next;
          if (last_row) state <= S_FINISH;
        end
        default: begin
          pop_count <= acc;
          gen_count <= gen_count + 16'd1;
          state     <= S_IDLE;
        end
      endcase
    end
  end

`ifdef GOL_ROW_ENGINE_STABLE_DETECT_EN
  logic diff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff   <= 1'b0;
      stable <= 1'b0;
    end else begin
      if (state == S_PRIME)
        diff <= 1'b0;
      else if (state == S_SWEEP && new_row != cur_row)
        diff <= 1'b1;
      if (state == S_FINISH)
        stable <= ~diff;
    end
  end
`else
  assign stable = 1'b0;
`endif

endmodule
